// File: rtl/cdc_hs_tx_ctrl.sv
// cdc_hs_tx_ctrl: source-side controller for a 4-phase req/ack handshake.
// Holds one accepted word on xfer_data, raises req_out, waits for the
// synchronised ack to rise, then drops req_out and waits for ack to fall.
// Optional ack-wait timeout with sticky err flag: define CDC_TIMEOUT_EN.
module cdc_hs_tx_ctrl #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT_W   = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              ack_in,
    output logic              req_out,
    output logic [DATA_W-1:0] xfer_data,
    output logic              done,
    output logic              busy,
    output logic [15:0]       xfer_cnt,
    output logic              err,
    input  logic              err_clr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ_HI = 2'd1,
        REQ_LO = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic                ack_s;
    logic                req_nxt;
    logic [DATA_W-1:0]   data_nxt;
    logic                done_nxt;
    logic                cnt_inc;
    logic                tmo_fire;

    // Plain flop chain bringing the remote ack into this clock domain
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_in};
        end
    end

    assign ack_s = ack_sync[SYNC_STAGES-1];

    // A stale ack left over from an aborted transfer holds off new words
    assign in_ready = (state == IDLE) && !ack_s;

`ifdef CDC_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] tmo_cnt;
    logic                 tmo_hit;

    assign tmo_hit = (state != IDLE) &&
                     (TIMEOUT_W'(tmo_cnt + TIMEOUT_W'(1)) == {TIMEOUT_W{1'b1}});

    // Cycles spent in the current wait state; restarts on every state change
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (state_nxt != state) begin
            tmo_cnt <= '0;
        end else if (state != IDLE) begin
            tmo_cnt <= TIMEOUT_W'(tmo_cnt + TIMEOUT_W'(1));
        end
    end

    // Sticky timeout flag; a timeout in the same cycle as err_clr wins
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (tmo_fire) begin
            err <= 1'b1;
        end else if (err_clr) begin
            err <= 1'b0;
        end
    end
`else
    logic unused_tmo;

    assign tmo_fire   = 1'b0;
    assign err        = 1'b0;
    assign unused_tmo = ^{err_clr, 1'(TIMEOUT_W)};
`endif

    // Next-state and next-output decode for the handshake
    always_comb begin
        state_nxt = state;
        req_nxt   = req_out;
        data_nxt  = xfer_data;
        done_nxt  = 1'b0;
        cnt_inc   = 1'b0;
`ifdef CDC_TIMEOUT_EN
        tmo_fire  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    data_nxt  = in_data;
                    req_nxt   = 1'b1;
                    state_nxt = REQ_HI;
                end
            end
            REQ_HI: begin
                if (ack_s) begin
                    req_nxt   = 1'b0;
                    state_nxt = REQ_LO;
                end
            end
            REQ_LO: begin
                if (!ack_s) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                    cnt_inc   = 1'b1;
                end
            end
            default: begin
                req_nxt   = 1'b0;
                state_nxt = IDLE;
            end
        endcase
`ifdef CDC_TIMEOUT_EN
        // Give up on a stuck wait: abort without a done pulse
        if (tmo_hit && (state_nxt == state)) begin
            tmo_fire  = 1'b1;
            req_nxt   = 1'b0;
            state_nxt = IDLE;
        end
`endif
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            req_out   <= 1'b0;
            xfer_data <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            req_out   <= req_nxt;
            xfer_data <= data_nxt;
            done      <= done_nxt;
            busy      <= (state_nxt != IDLE);
        end
    end

    // Completed-transfer counter, wraps naturally at 16 bits
    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_cnt <= '0;
        end else if (cnt_inc) begin
            xfer_cnt <= xfer_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_cdc_hs_tx_ctrl.sv
// Directed self-checking bench for cdc_hs_tx_ctrl (SYNC_STAGES=2, TIMEOUT_W=4).
// Inputs change 1 time unit after a rising edge, so a value driven after
// edge Tn-1 is first sampled at edge Tn. Outputs are checked at the same point.
module tb_cdc_hs_tx_ctrl;

    localparam int unsigned DATA_W = 8;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              ack_in;
    logic              req_out;
    logic [DATA_W-1:0] xfer_data;
    logic              done;
    logic              busy;
    logic [15:0]       xfer_cnt;
    logic              err;
    logic              err_clr;

    logic              ack_man;
    logic              rx_en;
    logic [2:0]        rx_pipe;

    int total;
    int bad;

    cdc_hs_tx_ctrl #(
        .DATA_W     (DATA_W),
        .SYNC_STAGES(2),
        .TIMEOUT_W  (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .ack_in   (ack_in),
        .req_out  (req_out),
        .xfer_data(xfer_data),
        .done     (done),
        .busy     (busy),
        .xfer_cnt (xfer_cnt),
        .err      (err),
        .err_clr  (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Receiver model: ack follows req three cycles later
    always @(posedge clk) rx_pipe <= {rx_pipe[1:0], req_out};
    assign ack_in = rx_en ? rx_pipe[2] : ack_man;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stimulus only: one full handshake with a hand-driven ack
    task automatic run_xfer(input logic [7:0] d, output bit ok);
        int n;
        ok = 1'b1;
        in_valid = 1'b1;
        in_data  = d;
        n = 0;
        do begin tick(); n++; end while (!req_out && n < 20);
        in_valid = 1'b0;
        if (!req_out) ok = 1'b0;
        ack_man = 1'b1;
        n = 0;
        do begin tick(); n++; end while (req_out && n < 20);
        if (req_out) ok = 1'b0;
        ack_man = 1'b0;
        n = 0;
        do begin tick(); n++; end while (!done && n < 20);
        if (!done) ok = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++; if (req_out !== 1'b0)   begin bad++; $display("FAIL rst_req got=%b exp=0", req_out); end
        total++; if (xfer_data !== 8'h00) begin bad++; $display("FAIL rst_data got=%h exp=00", xfer_data); end
        total++; if (done !== 1'b0)      begin bad++; $display("FAIL rst_done got=%b exp=0", done); end
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        total++; if (xfer_cnt !== 16'h0) begin bad++; $display("FAIL rst_cnt got=%h exp=0000", xfer_cnt); end
        total++; if (err !== 1'b0)       begin bad++; $display("FAIL rst_err got=%b exp=0", err); end
        rst = 1'b0;
        tick();
        total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL rst_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_basic();
        in_valid = 1'b1;
        in_data  = 8'hA5;
        tick(); // T0: accept
        in_valid = 1'b0;
        in_data  = 8'h00;
        total++; if (req_out !== 1'b1)    begin bad++; $display("FAIL basic_req_t0 got=%b exp=1", req_out); end
        total++; if (xfer_data !== 8'hA5) begin bad++; $display("FAIL basic_data_t0 got=%h exp=a5", xfer_data); end
        total++; if (busy !== 1'b1)       begin bad++; $display("FAIL basic_busy_t0 got=%b exp=1", busy); end
        total++; if (in_ready !== 1'b0)   begin bad++; $display("FAIL basic_ready_t0 got=%b exp=0", in_ready); end
        ack_man = 1'b1;
        tick(); // T1
        tick(); // T2: ack_s now high, req still up
        total++; if (req_out !== 1'b1)    begin bad++; $display("FAIL basic_req_t2 got=%b exp=1", req_out); end
        tick(); // T3
        total++; if (req_out !== 1'b0)    begin bad++; $display("FAIL basic_req_t3 got=%b exp=0", req_out); end
        ack_man = 1'b0;
        tick(); // T4
        tick(); // T5
        total++; if (done !== 1'b0)       begin bad++; $display("FAIL basic_done_t5 got=%b exp=0", done); end
        tick(); // T6
        total++; if (done !== 1'b1)       begin bad++; $display("FAIL basic_done_t6 got=%b exp=1", done); end
        total++; if (xfer_cnt !== 16'd1)  begin bad++; $display("FAIL basic_cnt got=%h exp=0001", xfer_cnt); end
        total++; if (busy !== 1'b0)       begin bad++; $display("FAIL basic_busy_t6 got=%b exp=0", busy); end
        tick(); // T7
        total++; if (done !== 1'b0)       begin bad++; $display("FAIL basic_done_t7 got=%b exp=0", done); end
        total++; if (in_ready !== 1'b1)   begin bad++; $display("FAIL basic_ready_t7 got=%b exp=1", in_ready); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] words [3];
        logic [7:0] got   [3];
        logic [7:0] held;
        logic       prev_req;
        int         k;
        int         viol;
        int         n;
        words[0] = 8'h01; words[1] = 8'h02; words[2] = 8'h03;
        got[0] = 8'h00; got[1] = 8'h00; got[2] = 8'h00;
        held = 8'h00; prev_req = 1'b0; k = 0; viol = 0; n = 0;
        rx_en    = 1'b1;
        in_valid = 1'b1;
        in_data  = words[0];
        while (!(k == 3 && !busy) && n < 200) begin
            tick();
            n++;
            if (req_out && !prev_req) begin
                if (k < 3) got[k] = xfer_data;
                held = xfer_data;
                k++;
                if (k < 3) in_data = words[k];
                else in_valid = 1'b0;
            end else if (req_out && (xfer_data !== held)) begin
                viol++;
            end
            prev_req = req_out;
        end
        in_valid = 1'b0;
        rx_en    = 1'b0;
        total++; if (k != 3)              begin bad++; $display("FAIL b2b_accepts got=%0d exp=3", k); end
        for (int i = 0; i < 3; i++) begin
            total++; if (got[i] !== words[i]) begin bad++; $display("FAIL b2b_word%0d got=%h exp=%h", i, got[i], words[i]); end
        end
        total++; if (viol != 0)           begin bad++; $display("FAIL b2b_stable got=%0d exp=0 changes", viol); end
        total++; if (xfer_cnt !== 16'd4)  begin bad++; $display("FAIL b2b_cnt got=%h exp=0004", xfer_cnt); end
        // let the receiver pipe drain before manual ack is used again
        repeat (6) tick();
    endtask

    task automatic test_data_hold();
        bit ok;
        in_valid = 1'b1;
        in_data  = 8'h3C;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_data = (i % 2 == 0) ? 8'hC3 : 8'h5A;
            tick();
            total++; if (xfer_data !== 8'h3C) begin bad++; $display("FAIL hold_data%0d got=%h exp=3c", i, xfer_data); end
        end
        total++; if (req_out !== 1'b1)     begin bad++; $display("FAIL hold_req got=%b exp=1", req_out); end
        ack_man = 1'b1;
        repeat (4) tick();
        ack_man = 1'b0;
        repeat (4) tick();
        total++; if (xfer_data !== 8'h3C)  begin bad++; $display("FAIL hold_after got=%h exp=3c", xfer_data); end
        total++; if (xfer_cnt !== 16'd5)   begin bad++; $display("FAIL hold_cnt got=%h exp=0005", xfer_cnt); end
        run_xfer(8'h96, ok);
        total++; if (!ok)                  begin bad++; $display("FAIL hold_next_xfer got=stuck exp=complete"); end
        total++; if (xfer_data !== 8'h96)  begin bad++; $display("FAIL hold_next_data got=%h exp=96", xfer_data); end
        tick();
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1;
        in_data  = 8'h77;
        tick();
        in_valid = 1'b0;
        ack_man  = 1'b1;
        tick(); // still in REQ_HI with ack on its way
        total++; if (req_out !== 1'b1)     begin bad++; $display("FAIL mid_req_pre got=%b exp=1", req_out); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (req_out !== 1'b0)     begin bad++; $display("FAIL mid_req got=%b exp=0", req_out); end
        total++; if (xfer_data !== 8'h00)  begin bad++; $display("FAIL mid_data got=%h exp=00", xfer_data); end
        total++; if (busy !== 1'b0)        begin bad++; $display("FAIL mid_busy got=%b exp=0", busy); end
        repeat (3) tick();
        total++; if (in_ready !== 1'b0)    begin bad++; $display("FAIL mid_ready_stale got=%b exp=0", in_ready); end
        ack_man = 1'b0;
        tick();
        total++; if (in_ready !== 1'b0)    begin bad++; $display("FAIL mid_ready_e1 got=%b exp=0", in_ready); end
        tick();
        total++; if (in_ready !== 1'b1)    begin bad++; $display("FAIL mid_ready_e2 got=%b exp=1", in_ready); end
        total++; if (xfer_cnt !== 16'd0)   begin bad++; $display("FAIL mid_cnt got=%h exp=0000", xfer_cnt); end
    endtask

    task automatic test_wrap();
        bit ok;
        force dut.xfer_cnt = 16'hFFFF;
        #1;
        release dut.xfer_cnt;
        tick();
        total++; if (xfer_cnt !== 16'hFFFF) begin bad++; $display("FAIL wrap_preload got=%h exp=ffff", xfer_cnt); end
        run_xfer(8'h42, ok);
        total++; if (!ok)                   begin bad++; $display("FAIL wrap_xfer got=stuck exp=complete"); end
        total++; if (xfer_cnt !== 16'h0000) begin bad++; $display("FAIL wrap_cnt got=%h exp=0000", xfer_cnt); end
        tick();
    endtask

    task automatic test_timeout();
`ifdef CDC_TIMEOUT_EN
        int dones;
        dones = 0;
        in_valid = 1'b1;
        in_data  = 8'h99;
        tick(); // T0
        in_valid = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            tick();
            if (done) dones++;
        end
        total++; if (err !== 1'b0)      begin bad++; $display("FAIL tmo_err_t14 got=%b exp=0", err); end
        total++; if (req_out !== 1'b1)  begin bad++; $display("FAIL tmo_req_t14 got=%b exp=1", req_out); end
        tick(); // T15
        if (done) dones++;
        total++; if (err !== 1'b1)      begin bad++; $display("FAIL tmo_err_t15 got=%b exp=1", err); end
        total++; if (req_out !== 1'b0)  begin bad++; $display("FAIL tmo_req_t15 got=%b exp=0", req_out); end
        total++; if (busy !== 1'b0)     begin bad++; $display("FAIL tmo_busy got=%b exp=0", busy); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL tmo_ready got=%b exp=1", in_ready); end
        tick();
        if (done) dones++;
        total++; if (dones != 0)        begin bad++; $display("FAIL tmo_done got=%0d exp=0 pulses", dones); end
        total++; if (xfer_cnt !== 16'h0000) begin bad++; $display("FAIL tmo_cnt got=%h exp=0000", xfer_cnt); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        total++; if (err !== 1'b0)      begin bad++; $display("FAIL tmo_clr got=%b exp=0", err); end
`else
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        total++; if (err !== 1'b0)      begin bad++; $display("FAIL noerr got=%b exp=0", err); end
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total    = 0;
        bad      = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        ack_man  = 1'b0;
        rx_en    = 1'b0;
        err_clr  = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_data_hold();
        test_reset_mid();
        test_wrap();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
